// File: rtl/conv3x3_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_sched_pkg
//  Description : Shared widths, read-count constants and sequencer state
//                encoding for the 3x3 convolution scheduler.
//  Contents    : IMG_DATA_WIDTH        - pixel / coefficient width
//                IMG_DATA_MATRIX_WIDTH - packed 3x3 window width
//                state_t               - IDLE/LOAD/FIRE/WAIT/EMIT/DONE
//  Revision    : 1.0 - initial release
// ============================================================================
package conv3x3_sched_pkg;

  localparam int IMG_DATA_WIDTH        = 8;
  localparam int IMG_DATA_MATRIX_WIDTH = 9 * IMG_DATA_WIDTH;

  // Reads needed for a fresh window (3 columns) and for a one-column slide.
  localparam logic [3:0] c_FULL_READS = 4'd9;
  localparam logic [3:0] c_COL_READS  = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIRE = 3'd2,
    ST_WAIT = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv3x3_window_reg.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_window_reg
//  Description : 3x3 pixel window with a left column shift and a per-slot
//                load. The packed output is row-major, top-left in the MSBs.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_shift       - move columns 1,2 into columns 0,1
//                i_load        - write i_data into slot (i_ld_row, i_ld_col)
//                i_data        - pixel to load
//                o_matrix      - packed window
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_window_reg #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_shift,
  input  logic            i_load,
  input  logic [1:0]      i_ld_row,
  input  logic [1:0]      i_ld_col,
  input  logic [DW-1:0]   i_data,
  output logic [9*DW-1:0] o_matrix
);

  logic [DW-1:0] r_win [0:2][0:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      if (i_shift) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
      end
      // Slot decode by comparison keeps every index constant.
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (i_load && (i_ld_row == 2'(r)) && (i_ld_col == 2'(c))) begin
            r_win[r][c] <= i_data;
          end
        end
      end
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign o_matrix[(8-(gr*3+gc))*DW +: DW] = r_win[gr][gc];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv3x3_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_sched
//  Description : Sweeps a 3x3 filter over an IMG_W x IMG_H image (valid-only
//                output map). Fetches pixels with column reuse, strobes the
//                filter, waits its latency and emits one result per window.
//  Ports       : clk, rst           - clock, asynchronous active-high reset
//                start, coef_in     - run request (IDLE only), coefficients
//                busy, done         - run in progress, end-of-run pulse
//                rd_en/rd_addr/rd_data - pixel memory read port
//                filt_ena/filt_in_matrix/filt_coef/filt_out - filter port
//                res_valid/res_addr/res_data - result stream
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_sched
  import conv3x3_sched_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int DW         = IMG_DATA_WIDTH,
  parameter int ADDR_W     = 16,
  parameter int FILTER_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9*DW-1:0]   coef_in,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              filt_ena,
  output logic [9*DW-1:0]   filt_in_matrix,
  output logic [9*DW-1:0]   filt_coef,
  input  logic [2*DW-1:0]   filt_out,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [2*DW-1:0]   res_data
);

  localparam logic [ADDR_W-1:0] c_IMG_W    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_OUT_W    = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] c_LAST_COL = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] c_LAST_ROW = ADDR_W'(IMG_H - 3);
  localparam int                c_WAIT_W   = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(FILTER_LAT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_row, r_col;
  logic                r_full;        // current window needs all 9 pixels
  logic [3:0]          r_cnt;         // cycle index inside LOAD
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_busy, r_done, r_rd_en, r_filt_ena, r_res_valid;
  logic [ADDR_W-1:0]   r_rd_addr, r_res_addr;
  logic [9*DW-1:0]     r_coef;
  logic [2*DW-1:0]     r_res_data;

  logic [3:0] w_nreads, w_cnt_nxt, w_ld_j;
  logic       w_ld_en, w_shift, w_more_cols, w_more_rows;
  logic [1:0] w_ld_row, w_ld_col;

  // Read j of a window: fresh windows walk columns 0..2 top to bottom,
  // slides fetch only the new right-hand column.
  function automatic logic [ADDR_W-1:0] f_rd_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col,
                                                  input logic              full,
                                                  input logic [3:0]        j);
    logic [ADDR_W-1:0] y, x;
    if (full) begin
      y = row + ADDR_W'(j % 4'd3);
      x = col + ADDR_W'(j / 4'd3);
    end else begin
      y = row + ADDR_W'(j);
      x = col + ADDR_W'(2);
    end
    return y * c_IMG_W + x;
  endfunction

  assign w_nreads    = r_full ? c_FULL_READS : c_COL_READS;
  assign w_cnt_nxt   = r_cnt + 4'd1;
  // Data for the read issued in LOAD cycle k arrives in cycle k+1.
  assign w_ld_j      = r_cnt - 4'd1;
  assign w_ld_en     = (r_state == ST_LOAD) && (r_cnt != 4'd0);
  assign w_ld_row    = r_full ? 2'(w_ld_j % 4'd3) : w_ld_j[1:0];
  assign w_ld_col    = r_full ? 2'(w_ld_j / 4'd3) : 2'd2;
  assign w_more_cols = r_col < c_LAST_COL;
  assign w_more_rows = r_row < c_LAST_ROW;
  assign w_shift     = (r_state == ST_EMIT) && w_more_cols;

  conv3x3_window_reg #(.DW(DW)) u_win (
    .clk      (clk),
    .rst      (rst),
    .i_shift  (w_shift),
    .i_load   (w_ld_en),
    .i_ld_row (w_ld_row),
    .i_ld_col (w_ld_col),
    .i_data   (rd_data),
    .o_matrix (filt_in_matrix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_full      <= 1'b0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_filt_ena  <= 1'b0;
      r_coef      <= '0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_res_data  <= '0;
    end else begin
      r_rd_en     <= 1'b0;
      r_filt_ena  <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_coef    <= coef_in;
            r_row     <= '0;
            r_col     <= '0;
            r_full    <= 1'b1;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt < w_nreads) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= f_rd_addr(r_row, r_col, r_full, w_cnt_nxt);
          end
          if (r_cnt == w_nreads) begin
            r_filt_ena <= 1'b1;
            r_state    <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          r_wait  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait == c_WAIT_LAST) begin
            r_res_valid <= 1'b1;
            r_res_data  <= filt_out;
            r_res_addr  <= r_row * c_OUT_W + r_col;
            r_state     <= ST_EMIT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_EMIT: begin
          r_cnt <= '0;
          if (w_more_cols) begin
            r_col     <= r_col + ADDR_W'(1);
            r_full    <= 1'b0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= f_rd_addr(r_row, r_col + ADDR_W'(1), 1'b0, 4'd0);
            r_state   <= ST_LOAD;
          end else if (w_more_rows) begin
            r_row     <= r_row + ADDR_W'(1);
            r_col     <= '0;
            r_full    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= f_rd_addr(r_row + ADDR_W'(1), '0, 1'b1, 4'd0);
            r_state   <= ST_LOAD;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign filt_ena  = r_filt_ena;
  assign filt_coef = r_coef;
  assign res_valid = r_res_valid;
  assign res_addr  = r_res_addr;
  assign res_data  = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv3x3_sched
//  Description : Scoreboard bench for conv3x3_sched. A 4x4 instance runs
//                deterministic and random images against a plain-arithmetic
//                convolution model; a 5x3 instance runs an all-ones image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_sched;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int LAT = 2;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [71:0]   coef_in = '0;
  logic          busy, done, rd_en, filt_ena, res_valid;
  logic [AW-1:0] rd_addr, res_addr;
  logic [7:0]    rd_data;
  logic [71:0]   filt_in_matrix, filt_coef;
  logic [15:0]   filt_out, res_data;

  logic          b_start = 1'b0;
  logic [71:0]   b_coef_in = '0;
  logic          b_busy, b_done, b_rd_en, b_filt_ena, b_res_valid;
  logic [AW-1:0] b_rd_addr, b_res_addr;
  logic [7:0]    b_rd_data;
  logic [71:0]   b_filt_in_matrix, b_filt_coef;
  logic [15:0]   b_filt_out, b_res_data;

  conv3x3_sched #(.IMG_W(W), .IMG_H(H), .DW(DW), .ADDR_W(AW), .FILTER_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .coef_in(coef_in), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .filt_ena(filt_ena),
    .filt_in_matrix(filt_in_matrix), .filt_coef(filt_coef), .filt_out(filt_out),
    .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
  );

  conv3x3_sched #(.IMG_W(5), .IMG_H(3), .DW(DW), .ADDR_W(AW), .FILTER_LAT(LAT)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .coef_in(b_coef_in), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .filt_ena(b_filt_ena),
    .filt_in_matrix(b_filt_in_matrix), .filt_coef(b_filt_coef), .filt_out(b_filt_out),
    .res_valid(b_res_valid), .res_addr(b_res_addr), .res_data(b_res_data)
  );

  // ---------------- environment: pixel memory and behavioural filter -------
  logic [7:0]  img [W*H];
  logic [15:0] fs0, fs1, b_fs0, b_fs1;

  function automatic logic [15:0] dot(input logic [71:0] m, input logic [71:0] k);
    logic [15:0] acc = '0;
    for (int i = 0; i < 9; i++) acc += 16'(m[(8-i)*8 +: 8]) * 16'(k[(8-i)*8 +: 8]);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= img[rd_addr[3:0]];
    if (filt_ena) fs0 <= dot(filt_in_matrix, filt_coef);
    fs1 <= fs0;
    if (b_filt_ena) b_fs0 <= dot(b_filt_in_matrix, b_filt_coef);
    b_fs1 <= b_fs0;
  end
  assign filt_out   = fs1;
  assign b_filt_out = b_fs1;
  assign b_rd_data  = 8'd1;

  // ---------------- scoreboard state ---------------------------------------
  int   checks = 0, failures = 0;
  int   cyc = 0, t0 = 0, exp_done_cyc = 0;
  bit   track = 0;
  logic [71:0] exp_coef = '0;
  res_t res_q[$];
  int   rd_q[$];
  res_t bq[$];
  int   rd_cnt = 0, ena_cnt = 0, res_cnt = 0, done_cnt = 0, b_done_cnt = 0;
  res_t m_e;
  int   m_a, rel;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=pulse expected=none", nm);
  endtask

  // Reference: direct 3x3 valid convolution plus the per-window cycle budget.
  task automatic model_run();
    int   t = 0;
    res_t e;
    for (int row = 0; row <= H-3; row++) begin
      for (int col = 0; col <= W-3; col++) begin
        if (col == 0) begin
          t += 12 + LAT;
          for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++) rd_q.push_back((row+y)*W + x);
        end else begin
          t += 6 + LAT;
          for (int y = 0; y < 3; y++) rd_q.push_back((row+y)*W + col + 2);
        end
        e.data = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.data += 16'(img[(row+r)*W + col + c]) * 16'(exp_coef[(8-(r*3+c))*8 +: 8]);
        e.addr = row*(W-2) + col;
        e.cyc  = t;
        res_q.push_back(e);
      end
    end
    exp_done_cyc = t + 1;
  endtask

  // ---------------- monitors -----------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      rel = cyc - t0;
      if (rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) unexpected("rd_en");
        else begin
          m_a = rd_q.pop_front();
          chk("rd_addr", 72'(rd_addr), 72'(m_a));
        end
      end
      if (filt_ena) ena_cnt++;
      if (res_valid) begin
        res_cnt++;
        if (res_q.size() == 0) unexpected("res_valid");
        else begin
          m_e = res_q.pop_front();
          chk("res_addr", 72'(res_addr), 72'(m_e.addr));
          chk("res_data", 72'(res_data), 72'(m_e.data));
          if (track) chk("res_cycle", 72'(rel), 72'(m_e.cyc));
        end
      end
      if (done) begin
        done_cnt++;
        if (track) chk("done_cycle", 72'(rel), 72'(exp_done_cyc));
      end
      if (track) begin
        chk("busy", 72'(busy), 72'(rel >= 1 && rel <= exp_done_cyc));
        if (busy) chk("filt_coef", filt_coef, exp_coef);
      end
      if (b_res_valid) begin
        if (bq.size() == 0) unexpected("b_res_valid");
        else begin
          m_e = bq.pop_front();
          chk("b_res_addr", 72'(b_res_addr), 72'(m_e.addr));
          chk("b_res_data", 72'(b_res_data), 72'(m_e.data));
        end
      end
      if (b_done) b_done_cnt++;
    end
  end

  // ---------------- stimulus -----------------------------------------------
  function automatic logic [71:0] rand72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic rand_image();
    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom);
  endtask

  task automatic run_a(input bit storm);
    int  base_done, base_rd;
    bit  got = 0;
    base_done = done_cnt;
    base_rd   = rd_cnt;
    exp_coef  = coef_in;
    model_run();
    t0    = cyc;
    track = 1;
    start = 1'b1;
    @(negedge clk);
    if (!storm) start = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (storm) coef_in = rand72();
      if (done) got = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    if (!got) unexpected("run_timeout");
    @(negedge clk);
    track = 0;
    repeat (10) @(negedge clk);
    chk("done_once", 72'(done_cnt - base_done), 72'd1);
    chk("rd_pulses", 72'(rd_cnt - base_rd), 72'd24);
    chk("res_q_empty", 72'(res_q.size()), 72'd0);
    chk("idle_busy", 72'(busy), 72'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 72'(busy), 72'd0);
    chk({tag, "_done"}, 72'(done), 72'd0);
    chk({tag, "_rd_en"}, 72'(rd_en), 72'd0);
    chk({tag, "_rd_addr"}, 72'(rd_addr), 72'd0);
    chk({tag, "_filt_ena"}, 72'(filt_ena), 72'd0);
    chk({tag, "_matrix"}, filt_in_matrix, 72'd0);
    chk({tag, "_coef"}, filt_coef, 72'd0);
    chk({tag, "_res_valid"}, 72'(res_valid), 72'd0);
    chk({tag, "_res_addr"}, 72'(res_addr), 72'd0);
    chk({tag, "_res_data"}, 72'(res_data), 72'd0);
  endtask

  initial begin
    res_t e;
    int   n, base;
    bit   got;

    // Reset values, then idle with start low.
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("powerup_busy", 72'(busy), 72'd0);
    chk("powerup_activity", 72'(rd_cnt + ena_cnt + res_cnt + done_cnt), 72'd0);

    // 5x3 all-ones image, coefficients 2: three results of 18.
    for (int i = 0; i < 3; i++) begin
      e.addr = i; e.data = 16'd18; e.cyc = 0;
      bq.push_back(e);
    end
    b_coef_in = {9{8'd2}};
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (b_done) got = 1;
      else @(negedge clk);
    end
    if (!got) unexpected("b_timeout");
    repeat (5) @(negedge clk);
    chk("b_done_once", 72'(b_done_cnt), 72'd1);
    chk("b_results", 72'(bq.size()), 72'd0);

    // Ramp image p = y*4+x, unit coefficients: 45, 54, 81, 90.
    for (int i = 0; i < W*H; i++) img[i] = 8'(i);
    coef_in = {9{8'd1}};
    run_a(0);

    // Random image and coefficients.
    rand_image();
    coef_in = rand72();
    run_a(0);

    // start held high for the whole run while coef_in churns.
    rand_image();
    coef_in = rand72();
    run_a(1);

    // Reset during the second WAIT aborts without a done pulse.
    rand_image();
    coef_in  = rand72();
    exp_coef = coef_in;
    model_run();
    base  = done_cnt;
    t0    = cyc;
    track = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      if (filt_ena) n++;
      if (n < 2) @(negedge clk);
    end
    if (n < 2) unexpected("abort_timeout");
    @(negedge clk);
    track = 0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("abort");
    res_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 72'(done_cnt - base), 72'd0);

    // A fresh run after the abort completes normally.
    rand_image();
    coef_in = rand72();
    run_a(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv3x3_sched.md
Name: conv3x3_sched

Overview:
Sequencer that sweeps the 3x3 convolution datapath (filter3x3) across an IMG_W x IMG_H image held in a single-port pixel memory, producing a valid-only (no padding) output map.
- Fetches pixels, assembles each window with column reuse, and presents it to the filter with a one-cycle enable.
- Waits the filter latency, then emits one result per window with its output address.
- Sits between the image buffer and filter3x3 in the conv layer.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
DW, `IMG_DATA_WIDTH, pixel/coefficient width
ADDR_W, 16, pixel and result address width
FILTER_LAT, 2, cycles from filt_ena high to filt_out valid (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
coef_in  in  9*DW  filter coefficients, latched when start is accepted
busy  out  1  high from the cycle after start acceptance until the done cycle inclusive
done  out  1  one-cycle pulse after the last result
rd_en  out  1  pixel read strobe
rd_addr  out  ADDR_W  pixel address = y*IMG_W + x
rd_data  in  DW  pixel, valid the cycle after rd_en
filt_ena  out  1  one-cycle window strobe to the filter
filt_in_matrix  out  9*DW  window, row-major, top-left pixel in MSBs
filt_coef  out  9*DW  latched coefficients, stable while busy
filt_out  in  2*DW  filter result
res_valid  out  1  one-cycle result strobe
res_addr  out  ADDR_W  row*(IMG_W-2) + col
res_data  out  2*DW  filt_out captured unchanged

Behaviour:
- Reset: state IDLE; all outputs, window registers, coefficient register and counters are 0. Reset asserted mid-operation aborts immediately; no done pulse is produced.
- States and transitions:
  - IDLE: start -> LOAD, latch coef_in, row=col=0. start while not IDLE is ignored, including during the done cycle.
  - LOAD: reads pixels in column order, top/mid/bottom of each column. At col 0 it reads 3 columns (9 reads); otherwise it shifts the window left one column and reads 1 new column (3 reads). Reads are issued back-to-back, one per cycle; rd_data is captured one cycle later. LOAD lasts N+1 cycles for N reads.
  - FIRE: filt_ena=1 for 1 cycle; filt_in_matrix stable from FIRE until the next LOAD.
  - WAIT: FILTER_LAT cycles.
  - EMIT: res_valid=1, res_data=filt_out, res_addr. Next state:
    - col<IMG_W-3: col++, -> LOAD(3).
    - else if row<IMG_H-3: row++, col=0, -> LOAD(9).
    - else -> DONE.
  - DONE: done=1 for 1 cycle, -> IDLE.
- Cycles per window: first window of a row takes 12+FILTER_LAT; every other window takes 6+FILTER_LAT.
- Arithmetic: no arithmetic is applied to results; address multiplies use constant parameters; no wrap, since addresses fit in ADDR_W by construction.
- Timing from start accepted at cycle 0:
  - LOAD begins cycle 1 and the first rd_en is in cycle 1.
  - With IMG_W=IMG_H=4 and FILTER_LAT=2, res_valid occurs at cycles 14, 22, 36, 44 and done at cycle 45.

Decomposition:
- Shared package/header (bit_width.vh): IMG_DATA_WIDTH, IMG_DATA_MATRIX_WIDTH, state encodings for IDLE/LOAD/FIRE/WAIT/EMIT/DONE.
- One sub-module, conv3x3_window_reg: 3x3 shift-by-column window register with a per-slot load of rd_data and a column-shift strobe.

Test Plan:
- 4x4 image, p(x,y)=y*4+x, coef all 1, behavioural filter with FILTER_LAT=2 -> results 45@addr0, 54@addr1, 81@addr2, 90@addr3 at cycles 14/22/36/44; done at 45.
- Same run, rd_addr trace -> 0,4,8,1,5,9,2,6,10 | 3,7,11 | 4,8,12,5,9,13,6,10,14 | 7,11,15; 24 rd_en pulses total.
- Pixels all 1, coef all 2 (NUM_2), 5x3 image -> 3 results, each 18, at res_addr 0,1,2; done once.
- start pulsed every cycle during a run -> single run, same result count, coefficients unchanged mid-run.
- rst asserted during second WAIT -> all outputs 0 next edge; no done; a new start then completes normally.
- Power-up with start=0 -> busy, rd_en, filt_ena, res_valid and done stay 0 indefinitely.
